// File: rtl/irq_scheduler.sv
// Purpose: edge-triggered 3-line interrupt scheduler with mask, overrun/timeout flags and bank strobe.
// Latency: edge at E0 -> pending after E0 -> eirq after E1 (unmasked, not busy).
// Backpressure: busy holds the FSM in IDLE; REQ waits for ack up to ACK_TIMEOUT cycles.
module irq_scheduler #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] irq_in,
    input  logic       mask_wr,
    input  logic [2:0] mask_data,
    input  logic       busy,
    input  logic       ack,
    input  logic       iret,
    input  logic       ovr_clr,
    output logic       eirq,
    output logic [1:0] vector,
    output logic       inter,
    output logic       sBank,
    output logic [1:0] sAddrBank,
    output logic [2:0] pending,
    output logic [2:0] overrun,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] prev_q, prev_d;
    logic [2:0] mask_q, mask_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] overrun_q, overrun_d;
    logic       timeout_q, timeout_d;
    logic [1:0] vector_q, vector_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sbank_q, sbank_d;
    logic [1:0] saddr_q, saddr_d;

    logic [2:0] edge_w;
    logic [2:0] req_w;
    logic [2:0] clr_w;
    logic       to_set;

    // Next-state, arbitration and flag update logic
    always_comb begin
        edge_w   = irq_in & ~prev_q;
        req_w    = pending_q & ~mask_q;
        state_d  = state_q;
        vector_d = vector_q;
        cnt_d    = cnt_q;
        sbank_d  = 1'b0;
        saddr_d  = 2'd0;
        clr_w    = 3'b000;
        to_set   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if ((req_w != 3'b000) && !busy) begin
                    state_d = REQ;
                    // Lowest index wins: irq1 has top priority
                    if (req_w[0])      vector_d = 2'd1;
                    else if (req_w[1]) vector_d = 2'd2;
                    else               vector_d = 2'd3;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = SERVICE;
                    cnt_d   = 8'd0;
                    sbank_d = 1'b1;
                    saddr_d = vector_q;
                    case (vector_q)
                        2'd1:    clr_w = 3'b001;
                        2'd2:    clr_w = 3'b010;
                        2'd3:    clr_w = 3'b100;
                        default: clr_w = 3'b000;
                    endcase
                end else if (cnt_q + 8'd1 == TO_LIMIT) begin
                    // Give up on this request; pending bit stays for a retry
                    state_d  = IDLE;
                    to_set   = 1'b1;
                    cnt_d    = 8'd0;
                    vector_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SERVICE: begin
                if (iret) begin
                    state_d  = RETURN;
                    vector_d = 2'd0;
                end
            end
            RETURN: begin
                state_d  = IDLE;
                vector_d = 2'd0;
            end
            default: begin
                state_d  = IDLE;
                vector_d = 2'd0;
            end
        endcase

        prev_d    = irq_in;
        mask_d    = mask_wr ? mask_data : mask_q;
        // A fresh edge beats the ack clear, and that case is not an overrun
        pending_d = (pending_q & ~clr_w) | edge_w;
        overrun_d = (ovr_clr ? 3'b000 : overrun_q) | (edge_w & pending_q & ~clr_w);
        timeout_d = (ovr_clr ? 1'b0 : timeout_q) | to_set;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= 3'b000;
            mask_q    <= 3'b000;
            pending_q <= 3'b000;
            overrun_q <= 3'b000;
            timeout_q <= 1'b0;
            vector_q  <= 2'd0;
            cnt_q     <= 8'd0;
            sbank_q   <= 1'b0;
            saddr_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            vector_q  <= vector_d;
            cnt_q     <= cnt_d;
            sbank_q   <= sbank_d;
            saddr_q   <= saddr_d;
        end
    end

    // Outputs decode directly from state so reset clears them immediately
    always_comb begin
        eirq      = (state_q == REQ);
        inter     = (state_q == SERVICE);
        vector    = vector_q;
        sBank     = sbank_q;
        sAddrBank = saddr_q;
        pending   = pending_q;
        overrun   = overrun_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler with ACK_TIMEOUT=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_irq_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_in;
    logic       mask_wr;
    logic [2:0] mask_data;
    logic       busy;
    logic       ack;
    logic       iret;
    logic       ovr_clr;
    logic       eirq;
    logic [1:0] vector;
    logic       inter;
    logic       sBank;
    logic [1:0] sAddrBank;
    logic [2:0] pending;
    logic [2:0] overrun;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    irq_scheduler #(.ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .busy      (busy),
        .ack       (ack),
        .iret      (iret),
        .ovr_clr   (ovr_clr),
        .eirq      (eirq),
        .vector    (vector),
        .inter     (inter),
        .sBank     (sBank),
        .sAddrBank (sAddrBank),
        .pending   (pending),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " eirq"},      8'(eirq),      8'h0);
        chk({tag, " vector"},    8'(vector),    8'h0);
        chk({tag, " inter"},     8'(inter),     8'h0);
        chk({tag, " sBank"},     8'(sBank),     8'h0);
        chk({tag, " sAddrBank"}, 8'(sAddrBank), 8'h0);
        chk({tag, " pending"},   8'(pending),   8'h0);
        chk({tag, " overrun"},   8'(overrun),   8'h0);
        chk({tag, " timeout"},   8'(timeout),   8'h0);
    endtask

    initial begin
        rst = 1'b1; irq_in = 3'b000; mask_wr = 1'b0; mask_data = 3'b000;
        busy = 1'b0; ack = 1'b0; iret = 1'b0; ovr_clr = 1'b0;
        #2;
        chk_all_zero("reset");
        step();
        rst = 1'b0;

        // Two lines rise together; irq2 wins
        irq_in = 3'b110; step();
        chk("e0 pending", 8'(pending), 8'h6);
        chk("e0 eirq",    8'(eirq),    8'h0);
        step();
        chk("e1 eirq",    8'(eirq),    8'h1);
        chk("e1 vector",  8'(vector),  8'h2);
        ack = 1'b1; step(); ack = 1'b0;
        chk("ack eirq",      8'(eirq),      8'h0);
        chk("ack inter",     8'(inter),     8'h1);
        chk("ack sBank",     8'(sBank),     8'h1);
        chk("ack sAddrBank", 8'(sAddrBank), 8'h2);
        chk("ack pending",   8'(pending),   8'h4);
        // ack inside SERVICE does nothing; strobe is one cycle
        ack = 1'b1; step(); ack = 1'b0;
        chk("svc sBank",   8'(sBank),   8'h0);
        chk("svc inter",   8'(inter),   8'h1);
        chk("svc pending", 8'(pending), 8'h4);
        chk("svc vector",  8'(vector),  8'h2);
        iret = 1'b1; step(); iret = 1'b0;
        chk("ret inter",  8'(inter),  8'h0);
        chk("ret vector", 8'(vector), 8'h0);
        chk("ret eirq",   8'(eirq),   8'h0);
        step();
        chk("idle eirq", 8'(eirq), 8'h0);
        step();
        chk("irq3 eirq",   8'(eirq),   8'h1);
        chk("irq3 vector", 8'(vector), 8'h3);

        // Service irq3, then two more irq3 edges during SERVICE
        ack = 1'b1; step(); ack = 1'b0;
        chk("irq3 svc inter",  8'(inter),     8'h1);
        chk("irq3 svc pend",   8'(pending),   8'h0);
        chk("irq3 saddr",      8'(sAddrBank), 8'h3);
        irq_in = 3'b010; step(); irq_in = 3'b110; step();
        chk("2nd edge pend", 8'(pending), 8'h4);
        chk("2nd edge ovr",  8'(overrun), 8'h0);
        irq_in = 3'b010; step(); irq_in = 3'b110; step();
        chk("3rd edge ovr",  8'(overrun), 8'h4);
        chk("no nest eirq",  8'(eirq),    8'h0);
        iret = 1'b1; step(); iret = 1'b0;
        chk("ret2 inter",  8'(inter),  8'h0);
        chk("ret2 vector", 8'(vector), 8'h0);
        step();
        chk("idle2 eirq", 8'(eirq), 8'h0);
        step();
        chk("rereq eirq",   8'(eirq),   8'h1);
        chk("rereq vector", 8'(vector), 8'h3);

        // Clear overrun, then an edge coinciding with the ack clear
        ovr_clr = 1'b1; irq_in = 3'b010; step(); ovr_clr = 1'b0;
        chk("ovr_clr", 8'(overrun), 8'h0);
        ack = 1'b1; irq_in = 3'b110; step(); ack = 1'b0;
        chk("coinc pending", 8'(pending), 8'h4);
        chk("coinc overrun", 8'(overrun), 8'h0);
        chk("coinc inter",   8'(inter),   8'h1);
        iret = 1'b1; step(); iret = 1'b0;
        step(); step();
        chk("to req eirq", 8'(eirq), 8'h1);

        // Never ack: 4 cycles of eirq then timeout
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to wait eirq", 8'(eirq), 8'h1);
        end
        step();
        chk("to eirq",    8'(eirq),    8'h0);
        chk("to flag",    8'(timeout), 8'h1);
        chk("to pending", 8'(pending), 8'h4);
        chk("to vector",  8'(vector),  8'h0);
        step();
        chk("to rereq eirq",   8'(eirq),   8'h1);
        chk("to rereq vector", 8'(vector), 8'h3);
        ack = 1'b1; step(); ack = 1'b0;
        iret = 1'b1; step(); iret = 1'b0;
        step();
        chk("to sticky",  8'(timeout), 8'h1);
        chk("to pend clr", 8'(pending), 8'h0);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("to clr", 8'(timeout), 8'h0);

        // Masked irq1 stays pending until unmasked
        mask_wr = 1'b1; mask_data = 3'b001; step(); mask_wr = 1'b0;
        irq_in = 3'b111; step();
        chk("mask pending", 8'(pending), 8'h1);
        chk("mask eirq",    8'(eirq),    8'h0);
        step();
        chk("mask eirq2", 8'(eirq), 8'h0);
        mask_wr = 1'b1; mask_data = 3'b000; step(); mask_wr = 1'b0;
        chk("unmask eirq0", 8'(eirq), 8'h0);
        step();
        chk("unmask eirq",   8'(eirq),   8'h1);
        chk("unmask vector", 8'(vector), 8'h1);
        mask_wr = 1'b1; mask_data = 3'b111; step(); mask_wr = 1'b0;
        chk("hold vector", 8'(vector), 8'h1);
        chk("hold eirq",   8'(eirq),   8'h1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("irq1 saddr",   8'(sAddrBank), 8'h1);
        chk("irq1 pending", 8'(pending),   8'h0);
        iret = 1'b1; step(); iret = 1'b0;
        step();

        // busy holds IDLE
        mask_wr = 1'b1; mask_data = 3'b000; irq_in = 3'b110; busy = 1'b1; step();
        mask_wr = 1'b0;
        irq_in = 3'b111; step();
        chk("busy pending", 8'(pending), 8'h1);
        step(); step();
        chk("busy eirq", 8'(eirq), 8'h0);
        busy = 1'b0; step();
        chk("unbusy eirq",   8'(eirq),   8'h1);
        chk("unbusy vector", 8'(vector), 8'h1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("pre-rst sBank", 8'(sBank), 8'h1);
        chk("pre-rst inter", 8'(inter), 8'h1);

        // Asynchronous reset mid-SERVICE, irq2 held high across release
        rst = 1'b1; irq_in = 3'b010; #2;
        chk_all_zero("async rst");
        step();
        rst = 1'b0;
        step();
        chk("post-rst pending", 8'(pending), 8'h2);
        chk("post-rst eirq",    8'(eirq),    8'h0);
        step();
        chk("post-rst req",    8'(eirq),   8'h1);
        chk("post-rst vector", 8'(vector), 8'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL set the max cycles waited in REQ for ack (1..255, 8-bit counter).
REQ-002 clk  in  1  core clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 irq_in  in  3  interrupt lines; bit0 = irq1 (highest priority), bit2 = irq3 (lowest).
REQ-005 mask_wr  in  1  when high, SHALL load mask_data into the mask register.
REQ-006 mask_data  in  3  new mask; 1 = line masked.
REQ-007 busy  in  1  core cannot take an interrupt this cycle (halt/multicycle op).
REQ-008 ack  in  1  core accepted the presented vector.
REQ-009 iret  in  1  core finished the handler.
REQ-010 ovr_clr  in  1  clears all overrun flags.
REQ-011 eirq  out  1  interrupt request to core.
REQ-012 vector  out  2  id of the requested/serviced line: 1, 2 or 3; 0 when idle.
REQ-013 inter  out  1  handler in service; drives core bank selection.
REQ-014 sBank  out  1  one-cycle bank-switch strobe.
REQ-015 sAddrBank  out  2  bank number, equal to vector while sBank is high.
REQ-016 pending  out  3  pending-request register.
REQ-017 overrun  out  3  sticky per-line lost-edge flags.
REQ-018 timeout  out  1  sticky flag, set when ack is not received within ACK_TIMEOUT.

Function
REQ-019 Edge detection SHALL use a registered copy of irq_in (prev); rising edge = irq_in & ~prev.
REQ-020 A rising edge SHALL set its pending bit regardless of mask or state.
REQ-021 An edge on a line whose pending bit is already 1 SHALL set its overrun bit.
REQ-022 Overrun bits SHALL clear only on ovr_clr; a set in the same cycle as ovr_clr SHALL win.
REQ-023 Mask SHALL gate arbitration only; a mask write SHALL take effect from the next cycle.
REQ-024 FSM states SHALL be IDLE, REQ, SERVICE, RETURN.
REQ-025 IDLE -> REQ when (pending & ~mask) != 0 and busy = 0; vector SHALL latch the lowest set index + 1 at that edge.
REQ-026 In REQ, eirq SHALL be 1 and vector SHALL be held stable; a later mask change or higher-priority edge SHALL NOT alter vector.
REQ-027 REQ -> SERVICE on ack: clear pending[vector-1], assert sBank for exactly one cycle with sAddrBank = vector, and drive eirq low from the next cycle.
REQ-028 If an edge on the serviced line coincides with the ack clear, set SHALL win: pending stays 1 and no overrun is raised.
REQ-029 In REQ, the wait counter SHALL increment each cycle without ack.
REQ-030 When the wait counter reaches ACK_TIMEOUT, the FSM SHALL go REQ -> IDLE, set timeout, keep the pending bit, and zero the counter.
REQ-031 In SERVICE, inter SHALL be 1 and no new eirq SHALL be raised; nesting is not supported.
REQ-032 SERVICE -> RETURN on iret; ack in SERVICE SHALL be ignored.
REQ-033 RETURN SHALL last one cycle with inter = 0 and vector = 0, then go to IDLE.
REQ-034 Request latency: edge sampled at clock edge E0 -> pending after E0 -> eirq high after E1, when unmasked and busy = 0.
REQ-035 iret outside SERVICE and ack outside REQ SHALL have no effect.
REQ-036 timeout SHALL clear only on ovr_clr.

Reset
REQ-037 On rst, all outputs, pending, overrun, mask, prev and the wait counter SHALL be 0 and the FSM SHALL be in IDLE, immediately and asynchronously.
REQ-038 rst asserted mid-REQ or mid-SERVICE SHALL abort the operation with no sBank pulse.
REQ-039 A line held high across reset release SHALL register one edge on the first clock after release (prev resets to 0).

Verification
REQ-040 irq_in=3'b110 rising in one cycle, mask=0 -> eirq after 2 clocks, vector=2; ack -> sBank 1-cycle pulse, sAddrBank=2, inter=1, pending=3'b100.
REQ-041 Service irq3, second irq3 edge during SERVICE, third irq3 edge -> overrun=3'b100; iret -> RETURN 1 cycle, then eirq again with vector=3.
REQ-042 mask=3'b001, irq1 edge -> no eirq, pending=3'b001; mask_wr 0 -> eirq 2 clocks later, vector=1.
REQ-043 ACK_TIMEOUT=4, never ack -> eirq high 4 cycles, then IDLE, timeout=1, pending kept; re-request follows.
REQ-044 busy=1 with pending -> stays IDLE; busy drops -> REQ next edge.
REQ-045 rst pulse while inter=1 -> all outputs 0 before the next clock edge; irq2 held high -> pending=3'b010 one clock after release.
